rr_pulse_sequencer: RTL and testbench

- Shares one `m_simple`-style pulse datapath between N requesters.
- Arbitrates round-robin among requesters and drives `in_signal` to the datapath for a programmed pulse length.
- Waits for the datapath's `out_signal` response, or a timeout, then returns a one-cycle `done` to the granted requester.
- Sits between requester logic and the single shared datapath instance; it is the only driver of the datapath's `in_signal`.

---
 rtl/rr_pulse_sequencer.sv | 164 ++++++++++++++++
 tb/tb_rr_pulse_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// rr_pulse_sequencer
//
// Round-robin front end for one shared pulse datapath. A granted requester gets
// a PULSE_LEN-cycle in_signal pulse driven to the datapath, then the sequencer
// waits for out_signal (or gives up after TIMEOUT cycles) and returns a
// one-cycle done to that requester.
//
// Ports:
//   clk          clock, everything on posedge
//   rst          synchronous active-high reset
//   req[N]       per-requester level request, held until done
//   gnt[N]       one-hot grant, high from DRIVE entry through DONE
//   done[N]      one-cycle completion pulse to the granted requester
//   busy         high whenever the sequencer is not IDLE
//   timeout_err  one-cycle pulse with done when the response never arrived
//   in_signal    stimulus to the shared datapath
//   out_signal   response from the shared datapath
// -----------------------------------------------------------------------------
module rr_pulse_sequencer #(
  parameter int N         = 4,
  parameter int PULSE_LEN = 2,
  parameter int TIMEOUT   = 8,
  parameter int CW        = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] done,
  output logic         busy,
  output logic         timeout_err,
  output logic         in_signal,
  input  logic         out_signal
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [IW-1:0] ptr_q,   ptr_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [N-1:0]  gnt_q,   gnt_d;
  logic          tmo_q,   tmo_d;

  logic          found_s;
  logic [IW-1:0] sel_s;
  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;

  // Round-robin pick: first set req bit at or above ptr_q, wrapping modulo N.
  // ptr_q < N and i < N, so one conditional subtraction is enough to wrap.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum_s >= (IW+1)'(N)) begin
        sum_s = sum_s - (IW+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IW-1:0];
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        sel_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic for the IDLE -> DRIVE -> WAIT -> DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_DRIVE;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << sel_s;
          idx_d   = sel_s;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end else begin
          gnt_d   = '0;
        end
      end
      S_DRIVE: begin
        // out_signal is deliberately not looked at while driving.
        if (cnt_q == CW'(PULSE_LEN - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        // A response on the timeout boundary still counts as a normal finish.
        if (out_signal) begin
          state_d = S_DONE;
          tmo_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        tmo_d   = 1'b0;
        ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        tmo_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs decode registered state only. in_signal is additionally masked by
  // rst so the datapath never sees a pulse in a cycle that is being reset.
  assign gnt         = gnt_q;
  assign done        = (state_q == S_DONE) ? gnt_q : '0;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = (state_q == S_DONE) & tmo_q;
  assign in_signal   = (state_q == S_DRIVE) & ~rst;

endmodule

// File: tb/tb_rr_pulse_sequencer.sv
module tb_rr_pulse_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       busy;
  logic       timeout_err;
  logic       in_signal;
  logic       out_signal;

  int checks;
  int errors;

  rr_pulse_sequencer #(
    .N(4), .PULSE_LEN(2), .TIMEOUT(8), .CW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gnt(gnt),
    .done(done),
    .busy(busy),
    .timeout_err(timeout_err),
    .in_signal(in_signal),
    .out_signal(out_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    req        = 4'b0000;
    out_signal = 1'b0;
    tick();
    tick();
    chk4("rst_gnt", gnt, 4'b0000);
    chk4("rst_done", done, 4'b0000);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in", in_signal, 1'b0);
    chk1("rst_te", timeout_err, 1'b0);
    rst = 1'b0;

    // Single request, response on the 2nd WAIT cycle.
    req = 4'b0001;
    tick();
    chk4("t1_gnt", gnt, 4'b0001);
    chk1("t1_in_c1", in_signal, 1'b1);
    chk1("t1_busy", busy, 1'b1);
    tick();
    chk1("t1_in_c2", in_signal, 1'b1);
    tick();
    chk1("t1_in_wait1", in_signal, 1'b0);
    chk4("t1_gnt_wait", gnt, 4'b0001);
    chk4("t1_nodone_w1", done, 4'b0000);
    tick();
    chk1("t1_in_wait2", in_signal, 1'b0);
    out_signal = 1'b1;
    tick();
    chk4("t1_done", done, 4'b0001);
    chk1("t1_te", timeout_err, 1'b0);
    chk4("t1_gnt_done", gnt, 4'b0001);
    out_signal = 1'b0;
    req = 4'b0000;
    tick();
    chk1("t1_busy_after", busy, 1'b0);
    chk4("t1_gnt_after", gnt, 4'b0000);
    chk4("t1_done_after", done, 4'b0000);

    // Reset so the pointer starts at 0, then rotate with all requests high.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick();
      chk4("rot_gnt", gnt, exp_g);
      chk4("rot_nodone_drv", done, 4'b0000);
      tick();
      tick();
      out_signal = 1'b1;
      tick();
      chk4("rot_done", done, exp_g);
      chk1("rot_te", timeout_err, 1'b0);
      out_signal = 1'b0;
      tick();
      chk4("rot_idle_done", done, 4'b0000);
      chk1("rot_idle_busy", busy, 1'b0);
    end
    req = 4'b0000;

    // Timeout: pointer is 1, only requester 2 asks, no response ever.
    req = 4'b0100;
    tick();
    chk4("to_gnt", gnt, 4'b0100);
    tick();
    tick();
    for (int w = 0; w < 8; w++) begin
      chk1("to_wait_in", in_signal, 1'b0);
      chk4("to_wait_done", done, 4'b0000);
      chk1("to_wait_busy", busy, 1'b1);
      tick();
    end
    chk4("to_done", done, 4'b0100);
    chk1("to_te", timeout_err, 1'b1);
    req = 4'b0000;
    tick();
    chk1("to_te_clear", timeout_err, 1'b0);
    chk1("to_busy_clear", busy, 1'b0);

    // Reset mid-DRIVE: pointer is 3, grant requester 3 then abort.
    req = 4'b1000;
    tick();
    chk4("ab_gnt", gnt, 4'b1000);
    chk1("ab_in", in_signal, 1'b1);
    rst = 1'b1;
    #1;
    chk1("ab_in_rst", in_signal, 1'b0);
    tick();
    rst = 1'b0;
    chk1("ab_in_after", in_signal, 1'b0);
    chk4("ab_gnt_after", gnt, 4'b0000);
    chk1("ab_busy_after", busy, 1'b0);
    chk4("ab_done_after", done, 4'b0000);

    // Pointer back at 0: from req 1010 requester 1 wins; drop it mid-flight.
    req = 4'b1010;
    tick();
    chk4("dr_gnt", gnt, 4'b0010);
    req = 4'b1000;
    tick();
    tick();
    out_signal = 1'b1;
    tick();
    chk4("dr_done", done, 4'b0010);
    out_signal = 1'b0;
    tick();
    chk4("dr_idle_gnt", gnt, 4'b0000);
    tick();
    chk4("dr_next_gnt", gnt, 4'b1000);
    tick();
    tick();
    out_signal = 1'b1;
    tick();
    chk4("dr_next_done", done, 4'b1000);
    out_signal = 1'b0;
    req = 4'b0000;
    tick();

    // Long reset with all requests and a toggling response.
    rst = 1'b1;
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      tick();
      out_signal = ~out_signal;
      #1;
      chk1("lr_in", in_signal, 1'b0);
      chk4("lr_gnt", gnt, 4'b0000);
      chk4("lr_done", done, 4'b0000);
      chk1("lr_busy", busy, 1'b0);
    end
    rst = 1'b0;
    req = 4'b0000;
    out_signal = 1'b0;
    tick();
    chk1("lr_busy_after", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
